// File: rtl/l1_i_controller_pkg.sv
// Shared definitions for the L1 instruction-cache tag/control slice.
// Controller state encoding and address field widths.
package l1_i_controller_pkg;

    typedef enum logic [1:0] {
        READY  = 2'd0,
        MISS   = 2'd1,
        REFILL = 2'd2
    } state_e;

    localparam int OFF_W = 6;
    localparam int BLK_W = 26;

endpackage

// File: rtl/l1_i_controller_if.sv
// Core fetch, flush and L2 line-request signals of the L1-I controller.
// master = core/L2 side, slave = controller side.
interface l1_i_controller_if
    import l1_i_controller_pkg::*;
#(
    parameter int TNUM   = 21,
    parameter int INUM   = BLK_W - TNUM,
    parameter int TNUM_2 = 18,
    parameter int INUM_2 = BLK_W - TNUM_2
);
    logic [TNUM-1:0]   tag_C_L1;
    logic [INUM-1:0]   index_C_L1;
    logic              read_C_L1;
    logic              flush;
    logic              ready_L2_L1;
    logic              stall;
    logic              refill;
    logic              way;
    logic              read_L1_L2;
    logic [INUM_2-1:0] index_L1_L2;
    logic [TNUM_2-1:0] tag_L1_L2;

    modport master (
        output tag_C_L1, index_C_L1, read_C_L1, flush, ready_L2_L1,
        input  stall, refill, way, read_L1_L2, index_L1_L2, tag_L1_L2
    );

    modport slave (
        input  tag_C_L1, index_C_L1, read_C_L1, flush, ready_L2_L1,
        output stall, refill, way, read_L1_L2, index_L1_L2, tag_L1_L2
    );
endinterface

// File: rtl/l1_i_tag_array.sv
// Tag/valid/LRU storage for a 2-way cache: combinational lookup and victim ports,
// synchronous tag/valid and LRU write ports, single-cycle clear of valid and LRU.
module l1_i_tag_array #(
    parameter int TNUM = 21,
    parameter int INUM = 5
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [INUM-1:0] lk_idx_i,
    input  logic [TNUM-1:0] lk_tag_i,
    output logic            hit_o,
    output logic            hit_way_o,
    input  logic [INUM-1:0] vic_idx_i,
    output logic            vic_way_o,
    input  logic            lru_we_i,
    input  logic [INUM-1:0] lru_idx_i,
    input  logic            lru_val_i,
    input  logic            tag_we_i,
    input  logic [INUM-1:0] tag_idx_i,
    input  logic            tag_way_i,
    input  logic [TNUM-1:0] tag_i,
    input  logic            clr_i
);
    localparam int SETS = 1 << INUM;

    logic [TNUM-1:0] tag0_q [SETS];
    logic [TNUM-1:0] tag1_q [SETS];
    logic [SETS-1:0] vld0_q, vld1_q, lru_q;
    logic            hit0, hit1;

    assign hit0      = vld0_q[lk_idx_i] && (tag0_q[lk_idx_i] == lk_tag_i);
    assign hit1      = vld1_q[lk_idx_i] && (tag1_q[lk_idx_i] == lk_tag_i);
    assign hit_o     = hit0 || hit1;
    assign hit_way_o = !hit0;

    // Fill invalid ways first, way0 preferred, before evicting the LRU way.
    always_comb begin
        vic_way_o = lru_q[vic_idx_i];
        if (!vld0_q[vic_idx_i]) begin
            vic_way_o = 1'b0;
        end else if (!vld1_q[vic_idx_i]) begin
            vic_way_o = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we_i) begin
            if (tag_way_i) begin
                tag1_q[tag_idx_i] <= tag_i;
            end else begin
                tag0_q[tag_idx_i] <= tag_i;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld0_q <= '0;
            vld1_q <= '0;
            lru_q  <= '0;
        end else if (clr_i) begin
            vld0_q <= '0;
            vld1_q <= '0;
            lru_q  <= '0;
        end else begin
            if (tag_we_i) begin
                if (tag_way_i) begin
                    vld1_q[tag_idx_i] <= 1'b1;
                end else begin
                    vld0_q[tag_idx_i] <= 1'b1;
                end
            end
            if (lru_we_i) begin
                lru_q[lru_idx_i] <= lru_val_i;
            end
        end
    end

endmodule

// File: rtl/l1_i_controller.sv
// L1 instruction-cache tag/control: 0-cycle hit, miss stalls the core and fetches the line from L2.
// Stall held from miss detection through the refill cycle; ready_L2_L1 only honoured in MISS.
module l1_i_controller
    import l1_i_controller_pkg::*;
#(
    parameter int TNUM   = 21,
    parameter int INUM   = BLK_W - TNUM,
    parameter int TNUM_2 = 18,
    parameter int INUM_2 = BLK_W - TNUM_2
) (
    input  logic              clk,
    input  logic              nrst,
    l1_i_controller_if.slave  bus
);
    state_e            state_q, state_d;
    logic [TNUM-1:0]   miss_tag_q, miss_tag_d;
    logic [INUM-1:0]   miss_idx_q, miss_idx_d;
    logic              flush_q, flush_pend_q, flush_pend_d;
    logic              read_q;
    logic              flush_edge, flush_apply;
    logic              hit, hit_way, vic_way;
    logic              lru_we, lru_val;
    logic [INUM-1:0]   lru_idx;
    logic              tag_we;
    logic              stall_c, refill_c, way_c;
    logic [BLK_W-1:0]  blk;

    l1_i_tag_array #(.TNUM(TNUM), .INUM(INUM)) u_tags (
        .clk       (clk),
        .nrst      (nrst),
        .lk_idx_i  (bus.index_C_L1),
        .lk_tag_i  (bus.tag_C_L1),
        .hit_o     (hit),
        .hit_way_o (hit_way),
        .vic_idx_i (miss_idx_q),
        .vic_way_o (vic_way),
        .lru_we_i  (lru_we),
        .lru_idx_i (lru_idx),
        .lru_val_i (lru_val),
        .tag_we_i  (tag_we),
        .tag_idx_i (miss_idx_q),
        .tag_way_i (vic_way),
        .tag_i     (miss_tag_q),
        .clr_i     (flush_apply)
    );

    // A flush edge seen mid-miss waits until the line has been written.
    assign flush_edge  = bus.flush && !flush_q;
    assign flush_apply = (state_q == READY) && (flush_edge || flush_pend_q);

    always_comb begin
        state_d      = state_q;
        miss_tag_d   = miss_tag_q;
        miss_idx_d   = miss_idx_q;
        flush_pend_d = flush_pend_q;
        stall_c      = 1'b0;
        refill_c     = 1'b0;
        way_c        = 1'b0;
        lru_we       = 1'b0;
        lru_idx      = bus.index_C_L1;
        lru_val      = 1'b0;
        tag_we       = 1'b0;

        if (flush_apply) begin
            flush_pend_d = 1'b0;
        end else if (flush_edge) begin
            flush_pend_d = 1'b1;
        end

        case (state_q)
            READY: begin
                if (bus.read_C_L1) begin
                    if (hit) begin
                        way_c   = hit_way;
                        lru_we  = 1'b1;
                        lru_val = !hit_way;
                    end else begin
                        stall_c    = 1'b1;
                        miss_tag_d = bus.tag_C_L1;
                        miss_idx_d = bus.index_C_L1;
                        state_d    = MISS;
                    end
                end
            end
            MISS: begin
                stall_c = 1'b1;
                if (bus.ready_L2_L1) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                stall_c  = 1'b1;
                refill_c = 1'b1;
                way_c    = vic_way;
                tag_we   = 1'b1;
                lru_we   = 1'b1;
                lru_idx  = miss_idx_q;
                lru_val  = !vic_way;
                state_d  = READY;
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= READY;
            miss_tag_q   <= '0;
            miss_idx_q   <= '0;
            flush_q      <= 1'b0;
            flush_pend_q <= 1'b0;
            read_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            miss_tag_q   <= miss_tag_d;
            miss_idx_q   <= miss_idx_d;
            flush_q      <= bus.flush;
            flush_pend_q <= flush_pend_d;
            read_q       <= (state_d == MISS);
        end
    end

    // Lookup logic is live during reset, so gate the combinational outputs.
    assign bus.stall       = nrst && stall_c;
    assign bus.refill      = nrst && refill_c;
    assign bus.way         = nrst && way_c;
    assign bus.read_L1_L2  = read_q;
    assign blk             = {miss_tag_q, miss_idx_q};
    assign bus.tag_L1_L2   = blk[BLK_W-1:INUM_2];
    assign bus.index_L1_L2 = blk[INUM_2-1:0];

endmodule

// File: tb/tb_l1_i_controller.sv
// Directed, table-driven bench for l1_i_controller: fills, hits, LRU, flush, async reset.
module tb_l1_i_controller;
    import l1_i_controller_pkg::*;

    typedef struct {
        logic [20:0] tag;
        logic [4:0]  idx;
        bit          hit;
        bit          way;
        int          lat;
    } vec_t;

    logic clk;
    logic nrst;
    int   n_tests;
    int   n_fail;
    vec_t vecs[$];
    logic [20:0] t0 [32];
    logic [20:0] t1 [32];

    l1_i_controller_if bus_if ();

    l1_i_controller dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one fetch from the cycle after a posedge; returns one cycle after completion.
    task automatic access(input logic [20:0] t, input logic [4:0] i, input bit exp_hit,
                          input bit exp_way, input int lat, input bit flush_in_miss);
        logic [31:0] addr;
        addr = {t, i, {OFF_W{1'b0}}};
        bus_if.tag_C_L1   = t;
        bus_if.index_C_L1 = i;
        bus_if.read_C_L1  = 1'b1;
        @(negedge clk);
        chk($sformatf("stall_req t=%0h i=%0d", t, i), 32'(bus_if.stall), 32'(!exp_hit));
        if (exp_hit) begin
            chk($sformatf("hit_way t=%0h i=%0d", t, i), 32'(bus_if.way), 32'(exp_way));
            chk($sformatf("hit_noreq t=%0h i=%0d", t, i), 32'(bus_if.read_L1_L2), 32'd0);
            step();
            return;
        end
        step();
        bus_if.tag_C_L1  = ~t;
        bus_if.read_C_L1 = 1'b0;
        if (flush_in_miss) bus_if.flush = 1'b1;
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            chk($sformatf("miss_req_wait i=%0d", i), 32'(bus_if.read_L1_L2), 32'd1);
            step();
        end
        bus_if.ready_L2_L1 = 1'b1;
        @(negedge clk);
        chk($sformatf("miss_req i=%0d", i), 32'(bus_if.read_L1_L2), 32'd1);
        chk($sformatf("miss_stall i=%0d", i), 32'(bus_if.stall), 32'd1);
        chk($sformatf("l2_tag i=%0d", i), 32'(bus_if.tag_L1_L2), 32'(addr[31:14]));
        chk($sformatf("l2_idx i=%0d", i), 32'(bus_if.index_L1_L2), 32'(addr[13:6]));
        step();
        bus_if.ready_L2_L1 = 1'b0;
        bus_if.tag_C_L1    = t;
        bus_if.read_C_L1   = 1'b1;
        @(negedge clk);
        chk($sformatf("refill i=%0d", i), 32'(bus_if.refill), 32'd1);
        chk($sformatf("refill_way t=%0h i=%0d", t, i), 32'(bus_if.way), 32'(exp_way));
        chk($sformatf("refill_stall i=%0d", i), 32'(bus_if.stall), 32'd1);
        chk($sformatf("refill_req_off i=%0d", i), 32'(bus_if.read_L1_L2), 32'd0);
        step();
        @(negedge clk);
        chk($sformatf("post_fill_stall i=%0d", i), 32'(bus_if.stall), 32'd0);
        chk($sformatf("post_fill_way i=%0d", i), 32'(bus_if.way), 32'(exp_way));
        chk($sformatf("post_fill_refill i=%0d", i), 32'(bus_if.refill), 32'd0);
        step();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 32; i++) begin
            t0[i] = 21'h0A000 + 21'(i);
            t1[i] = 21'h15000 + 21'(i * 3);
        end
        for (int i = 0; i < 32; i++) vecs.push_back('{t0[i], 5'(i), 1'b0, 1'b0, i % 3});
        for (int i = 0; i < 32; i++) vecs.push_back('{t1[i], 5'(i), 1'b0, 1'b1, (i + 1) % 3});
        for (int i = 0; i < 32; i++) begin
            vecs.push_back('{t0[i], 5'(i), 1'b1, 1'b0, 0});
            vecs.push_back('{t1[i], 5'(i), 1'b1, 1'b1, 0});
        end
        vecs.push_back('{21'h1AAAA, 5'd5, 1'b0, 1'b0, 0});
        vecs.push_back('{21'h1BBBB, 5'd5, 1'b0, 1'b1, 1});
        vecs.push_back('{21'h1CCCC, 5'd5, 1'b0, 1'b0, 0});
        vecs.push_back('{21'h1AAAA, 5'd5, 1'b0, 1'b1, 2});
        vecs.push_back('{21'h1CCCC, 5'd5, 1'b1, 1'b0, 0});

        nrst               = 1'b0;
        bus_if.tag_C_L1    = t0[0];
        bus_if.index_C_L1  = 5'd0;
        bus_if.read_C_L1   = 1'b1;
        bus_if.flush       = 1'b0;
        bus_if.ready_L2_L1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_stall", 32'(bus_if.stall), 32'd0);
        chk("rst_refill", 32'(bus_if.refill), 32'd0);
        chk("rst_way", 32'(bus_if.way), 32'd0);
        chk("rst_req", 32'(bus_if.read_L1_L2), 32'd0);
        chk("rst_l2_tag", 32'(bus_if.tag_L1_L2), 32'd0);
        chk("rst_l2_idx", 32'(bus_if.index_L1_L2), 32'd0);
        bus_if.read_C_L1 = 1'b0;
        step();
        nrst = 1'b1;
        step();
        bus_if.ready_L2_L1 = 1'b1;
        @(negedge clk);
        chk("idle_ready_ignored_stall", 32'(bus_if.stall), 32'd0);
        step();
        bus_if.ready_L2_L1 = 1'b0;
        @(negedge clk);
        chk("idle_ready_ignored_req", 32'(bus_if.read_L1_L2), 32'd0);
        step();

        foreach (vecs[n]) access(vecs[n].tag, vecs[n].idx, vecs[n].hit, vecs[n].way, vecs[n].lat, 1'b0);
        bus_if.read_C_L1 = 1'b0;

        // Flush held high throughout the refills: only the rising edge invalidates.
        bus_if.flush = 1'b1;
        repeat (50) step();
        for (int i = 0; i < 32; i++) access(t0[i], 5'(i), 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 32; i++) access(t1[i], 5'(i), 1'b0, 1'b1, 0, 1'b0);
        bus_if.flush = 1'b0;
        step();
        access(t0[0], 5'd0, 1'b1, 1'b0, 0, 1'b0);
        access(t1[31], 5'd31, 1'b1, 1'b1, 0, 1'b0);

        // Flush edge during MISS: refill completes, then the invalidate lands.
        access(21'h12345, 5'd7, 1'b0, 1'b0, 0, 1'b1);
        bus_if.flush = 1'b0;
        access(21'h12345, 5'd7, 1'b0, 1'b0, 1, 1'b0);
        access(t0[7], 5'd7, 1'b0, 1'b1, 0, 1'b0);
        access(21'h12345, 5'd7, 1'b1, 1'b0, 0, 1'b0);

        // Async reset mid-miss.
        bus_if.tag_C_L1   = 21'h0F0F0;
        bus_if.index_C_L1 = 5'd9;
        bus_if.read_C_L1  = 1'b1;
        @(negedge clk);
        chk("arst_pre_stall", 32'(bus_if.stall), 32'd1);
        step();
        @(negedge clk);
        chk("arst_pre_req", 32'(bus_if.read_L1_L2), 32'd1);
        #2;
        nrst = 1'b0;
        #1;
        chk("arst_req", 32'(bus_if.read_L1_L2), 32'd0);
        chk("arst_stall", 32'(bus_if.stall), 32'd0);
        chk("arst_refill", 32'(bus_if.refill), 32'd0);
        chk("arst_way", 32'(bus_if.way), 32'd0);
        chk("arst_l2_tag", 32'(bus_if.tag_L1_L2), 32'd0);
        chk("arst_l2_idx", 32'(bus_if.index_L1_L2), 32'd0);
        step();
        nrst = 1'b1;
        bus_if.read_C_L1 = 1'b0;
        step();
        access(21'h12345, 5'd7, 1'b0, 1'b0, 0, 1'b0);
        access(t0[7], 5'd7, 1'b0, 1'b1, 0, 1'b0);

        bus_if.read_C_L1 = 1'b0;
        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish (tests %0d)", n_tests);
        $fatal(1, "timeout");
    end

endmodule
